// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - programmable LED blink sequencer
// Divider tick steps through a {led, dur} table; each entry shows for eff(dur)*P clocks.
module led_pattern_sequencer #(
  parameter int CNT_W    = 27,
  parameter int NUM_LEDS = 4,
  parameter int DEPTH    = 8,
  localparam int IW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [IW-1:0]       cfg_addr,
  input  logic [NUM_LEDS-1:0] cfg_led,
  input  logic [7:0]          cfg_dur,
  input  logic [CNT_W-1:0]    period_in,
  input  logic [IW-1:0]       last_step,
  input  logic                loop,
  input  logic                start,
  input  logic                stop,
  output logic [NUM_LEDS-1:0] led,
  output logic [CNT_W-1:0]    A,
  output logic                tick,
  output logic [IW-1:0]       step_idx,
  output logic                busy,
  output logic                done
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_a;
  logic [CNT_W-1:0]    r_p;
  logic [NUM_LEDS-1:0] r_led;
  logic [IW-1:0]       r_step;
  logic [IW-1:0]       r_l;
  logic                r_lp;
  logic [7:0]          r_rem;
  logic                r_done;
  logic [NUM_LEDS-1:0] r_tbl_led [DEPTH];
  logic [7:0]          r_tbl_dur [DEPTH];

  logic                w_tick;
  logic                w_start_ok;
  logic                w_cfg_fire;
  logic                w_at_last;
  logic                w_finish;
  logic [IW-1:0]       w_step_nxt;

  // A zero duration still shows the entry for one tick
  function automatic logic [7:0] eff(input logic [7:0] d);
    return (d == 8'd0) ? 8'd1 : d;
  endfunction

  assign w_tick     = (r_state == S_RUN) && (r_a == r_p - CNT_W'(1));
  assign w_start_ok = start && !stop;
  assign w_cfg_fire = cfg_valid && cfg_ready;
  assign w_at_last  = (r_step == r_l);
  assign w_finish   = w_tick && (r_rem == 8'd1) && w_at_last && !r_lp;
  assign w_step_nxt = r_step + IW'(1);

  assign cfg_ready = (r_state == S_IDLE);
  assign busy      = (r_state == S_RUN);
  assign led       = r_led;
  assign A         = r_a;
  assign tick      = w_tick;
  assign step_idx  = r_step;
  assign done      = r_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_start_ok) w_next_state = S_RUN;
      S_RUN:  if (stop || w_finish) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tbl_led[i] <= '0;
        r_tbl_dur[i] <= '0;
      end
    end else if (w_cfg_fire) begin
      r_tbl_led[cfg_addr] <= cfg_led;
      r_tbl_dur[cfg_addr] <= cfg_dur;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a    <= '0;
      r_p    <= '0;
      r_led  <= '0;
      r_step <= '0;
      r_l    <= '0;
      r_lp   <= 1'b0;
      r_rem  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_p    <= (period_in == '0) ? CNT_W'(1) : period_in;
            r_l    <= last_step;
            r_lp   <= loop;
            r_a    <= '0;
            r_step <= '0;
            r_led  <= r_tbl_led[0];
            r_rem  <= eff(r_tbl_dur[0]);
          end
        end
        S_RUN: begin
          if (stop) begin
            r_a    <= '0;
            r_led  <= '0;
            r_step <= '0;
          end else if (!w_tick) begin
            r_a <= r_a + CNT_W'(1);
          end else begin
            r_a <= '0;
            if (r_rem > 8'd1) begin
              r_rem <= r_rem - 8'd1;
            end else if (!w_at_last) begin
              r_step <= w_step_nxt;
              r_led  <= r_tbl_led[w_step_nxt];
              r_rem  <= eff(r_tbl_dur[w_step_nxt]);
            end else if (r_lp) begin
              r_step <= '0;
              r_led  <= r_tbl_led[0];
              r_rem  <= eff(r_tbl_dur[0]);
            end else begin
              r_led  <= '0;
              r_step <= '0;
              r_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/led_pattern_sequencer.md
# led_pattern_sequencer

Programmable LED blink sequencer for the BlinkLEDs design. It owns a CNT_W-bit clock-frequency divider counter and uses its tick to step through a small pattern table of (LED value, duration) entries. The table is written over a valid/ready config port. Runs play once or loop, and can be stopped at any time. It sits between the board clock and the LED pins, replacing the fixed-rate divider as the block that decides what the LEDs show and for how long.

## Interface
- CNT_W, 27, width of divider counter A and period
- NUM_LEDS, 4, LED output width
- DEPTH, 8, pattern table entries (power of two); IW = log2(DEPTH)
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- cfg_valid  in  1  table write request
- cfg_ready  out  1  table write accepted when cfg_valid & cfg_ready at clk edge
- cfg_addr  in  IW  table entry index
- cfg_led  in  NUM_LEDS  LED value for entry
- cfg_dur  in  8  entry duration in ticks
- period_in  in  CNT_W  clocks per tick, latched at start
- last_step  in  IW  index of final entry, latched at start
- loop  in  1  1 = wrap after last_step, latched at start
- start  in  1  begin run (level sampled per edge)
- stop  in  1  abort run
- led  out  NUM_LEDS  registered LED drive
- A  out  CNT_W  divider count
- tick  out  1  divider terminal count, combinational from registers
- step_idx  out  IW  current entry index
- busy  out  1  1 in RUN
- done  out  1  one-cycle pulse at end of non-loop run

## Operation
- States: IDLE, RUN. busy = (state==RUN); cfg_ready = ~busy.
- Table: DEPTH entries of {led, dur}. Written only in IDLE. Writes in RUN are dropped (cfg_ready=0). All entries reset to {0,0}.
- Latched on start: P = (period_in==0) ? 1 : period_in; L = last_step; LP = loop.
- IDLE: A=0, led=0, step_idx=0. start & ~stop -> RUN. start & stop together -> stay IDLE (stop wins).
- Entering RUN (same edge): A<=0, step_idx<=0, led<=tbl[0].led, rem<=eff(tbl[0].dur), where eff(d) = (d==0) ? 1 : d.
- RUN: tick = (A==P-1). On ~tick, A<=A+1. On tick, A<=0 and:
  - rem>1: rem<=rem-1.
  - rem==1 and step_idx!=L: step_idx+1, new led, new rem.
  - rem==1, step_idx==L, LP=1: step_idx<=0, reload entry 0.
  - rem==1, step_idx==L, LP=0: state<=IDLE, led<=0, step_idx<=0, done<=1 for one cycle.
- Each entry's LED value is held for exactly eff(dur)*P clocks.
- stop in RUN: next edge -> IDLE, A=0, led=0, step_idx=0, no done. start in RUN is ignored.
- L beyond written entries is legal; it plays the reset {0,0} entries (LED off, 1 tick each).
- rem is 8 bits; arithmetic on A is unsigned CNT_W, no overflow because A < P ≤ 2^CNT_W-1.

## Timing
- Reset (reset=0) values: state IDLE, A=0, led=0, tick=0, step_idx=0, busy=0, done=0, cfg_ready=1, table cleared, P/L/LP=0.
- Reset asserted mid-run aborts immediately, asynchronously; no done.
- start -> busy=1 and led=tbl[0].led at the same sampling edge (1-clock latency from start assertion).
- cfg write takes effect at the accepting edge; a start on the following edge sees it.
- done asserts on the edge that returns to IDLE; it is low the next cycle unless a new run ends.
- tick is high exactly one cycle out of every P in RUN. It is continuously 1 when P=1.

## Test plan
- Reset: drive reset=0 mid-RUN -> all outputs at reset values within the same cycle; after release, cfg_ready=1, led=0.
- Single run: entries {0001,2},{0010,1},{0100,3}; period_in=5, last_step=2, loop=0; start -> led=0001 for 10 clk, 0010 for 5, 0100 for 15; done pulse at clk 30; then led=0, busy=0.
- Loop then stop: same table, loop=1 -> at clk 30, step_idx=0 and led=0001, no done; stop at clk 37 -> IDLE next edge, led=0, no done.
- Degenerate: period_in=0, entries {1010,0},{0101,0}, last_step=1, loop=0 -> tick every clk, led 1010 for 1 clk, 0101 for 1 clk, done on the 2nd edge.
- Handshake: cfg write during RUN -> cfg_ready=0, table unchanged after run. start during RUN -> ignored. start&stop together in IDLE -> stays IDLE.
